// File: rtl/ad9826_serial_master.sv
// 3-wire serial-port master for AD9826-class AFEs: command/response handshake, internal SCLK divider.
// Optional macro AD9826_VERIFY_EN appends an automatic read-back frame after every write.
module ad9826_serial_master #(
  parameter int ADDR_W   = 3,
  parameter int DC_W     = 3,
  parameter int DATA_W   = 9,
  parameter int HALF_PER = 4,
  parameter int GAP_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              ad_sclk,
  output logic              ad_sload,
  output logic              ad_sdata_o,
  output logic              ad_sdata_oe,
  input  logic              ad_sdata_i
);

  localparam int N        = 1 + ADDR_W + DC_W + DATA_W;
  localparam int CMD_BITS = 1 + ADDR_W + DC_W;
  localparam int CNT_MAX  = (HALF_PER > GAP_CYC) ? HALF_PER : GAP_CYC;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W    = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [N-1:0]        shreg_q, shreg_d;
  logic                sdo_q, sdo_d;
  logic                oe_q, oe_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef AD9826_VERIFY_EN
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                vphase_q, vphase_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  logic half_done;
  logic gap_done;
  logic last_bit;
  logic frame_rd;

  function automatic logic [N-1:0] build_frame(input logic rw,
                                               input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] data);
    return {rw, addr, {DC_W{1'b0}}, data};
  endfunction

  assign half_done = (cnt_q == CNT_W'(HALF_PER - 1));
  assign gap_done  = (cnt_q == CNT_W'(GAP_CYC - 1));
  assign last_bit  = (bit_q == BIT_W'(N - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    rw_d        = rw_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef AD9826_VERIFY_EN
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vphase_d    = vphase_q;
    rsp_err_d   = rsp_err_q;
    frame_rd    = rw_q | vphase_q;
`else
    frame_rd    = rw_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          shreg_d = build_frame(cmd_rw, cmd_addr, cmd_rw ? '0 : cmd_wdata);
          sdo_d   = cmd_rw;
          oe_d    = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
`ifdef AD9826_VERIFY_EN
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          vphase_d = 1'b0;
`endif
        end
      end

      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (half_done) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        cnt_d = cnt_q + 1'b1;
        if (half_done) begin
          cnt_d   = '0;
          state_d = SHIFT_LO;
          shreg_d = shreg_q << 1;
          sdo_d   = shreg_q[N-2];
          // Data bits of a read: AFE output is stable late in the high phase.
          if (frame_rd && (bit_q >= BIT_W'(CMD_BITS)))
            rdata_d = {rdata_q[DATA_W-2:0], ad_sdata_i};
          if (frame_rd && (bit_q >= BIT_W'(CMD_BITS - 1))) begin
            sdo_d = 1'b0;
            oe_d  = 1'b0;
          end
        end
      end

      SHIFT_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (half_done) begin
          cnt_d = '0;
          if (last_bit) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_HI;
          end
        end
      end

      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (half_done) begin
          cnt_d   = '0;
          state_d = GAP;
          sdo_d   = 1'b0;
          oe_d    = 1'b0;
        end
      end

      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_done) begin
          cnt_d   = '0;
          state_d = DONE;
          if (frame_rd) rsp_rdata_d = rdata_q;
`ifdef AD9826_VERIFY_EN
          rsp_err_d = vphase_q && (rdata_q != wdata_q);
          // A plain write chains straight into its read-back frame.
          if (!rw_q && !vphase_q) begin
            state_d     = SETUP;
            vphase_d    = 1'b1;
            shreg_d     = build_frame(1'b1, addr_q, '0);
            sdo_d       = 1'b1;
            oe_d        = 1'b1;
            bit_d       = '0;
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      rw_q        <= 1'b0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
`ifdef AD9826_VERIFY_EN
      addr_q      <= '0;
      wdata_q     <= '0;
      vphase_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      rw_q        <= rw_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AD9826_VERIFY_EN
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vphase_q    <= vphase_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rsp_rdata_q;
  assign ad_sclk     = (state_q == SHIFT_HI);
  assign ad_sload    = !(state_q inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});
  assign ad_sdata_o  = sdo_q;
  assign ad_sdata_oe = oe_q;
`ifdef AD9826_VERIFY_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ad9826_serial_master.sv
// Scoreboard bench for ad9826_serial_master with a behavioural AFE register model.
// Expectations follow AD9826_VERIFY_EN when the bench is built with that macro.
module tb_ad9826_serial_master;

`ifdef AD9826_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LAT       = VERIFY ? 281 : 141;
  localparam int GAP_MIN   = VERIFY ? 4 : 6;
  localparam int FR_PER_WR = VERIFY ? 2 : 1;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [2:0] cmd_addr;
  logic [8:0] cmd_wdata;
  logic       rsp_valid, rsp_err, busy;
  logic [8:0] rsp_rdata;
  logic       ad_sclk, ad_sload, ad_sdata_o, ad_sdata_oe, ad_sdata_i;

  ad9826_serial_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .ad_sclk    (ad_sclk),
    .ad_sload   (ad_sload),
    .ad_sdata_o (ad_sdata_o),
    .ad_sdata_oe(ad_sdata_oe),
    .ad_sdata_i (ad_sdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [8:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- AFE model ----------------
  logic [8:0]  mem [0:7];
  logic [15:0] fshift, wr_frame;
  logic [8:0]  rd_val, ovr_val;
  logic [2:0]  ovr_addr;
  logic        frm_rw, ovr_en, corrupt;
  int          fcnt, frames;

  initial begin
    fcnt = 0; frames = 0; fshift = '0; wr_frame = '0; frm_rw = 1'b0;
    rd_val = '0; ad_sdata_i = 1'b0;
  end

  always @(negedge ad_sload) begin
    fcnt   = 0;
    fshift = '0;
  end

  always @(posedge ad_sclk) if (!ad_sload) begin
    if (fcnt == 0) frm_rw = ad_sdata_o;
    fshift = {fshift[14:0], ad_sdata_o};
    fcnt++;
  end

  always @(negedge ad_sclk) if (!ad_sload && frm_rw && fcnt >= 7 && fcnt < 16) begin
    if (fcnt == 7)
      rd_val = ((ovr_en && fshift[5:3] == ovr_addr) ? ovr_val : mem[fshift[5:3]])
               ^ (corrupt ? 9'h001 : 9'h000);
    ad_sdata_i = rd_val[15 - fcnt];
  end

  always @(posedge ad_sload) begin
    if (fcnt == 16) begin
      frames++;
      if (!frm_rw) begin
        mem[fshift[14:12]] = fshift[8:0];
        wr_frame = fshift;
      end
    end
    ad_sdata_i = 1'b0;
  end

  // ---------------- monitor ----------------
  int   acc_cyc = 0, acc_count = 0, rsp_count = 0, lat = 0;
  int   low_cnt = 0, hi_cnt = 0, last_low = 0, min_hi = 1000000;
  int   oe_fall_at = -1;
  logic oe_fall_sclk = 1'b1, prev_oe = 1'b0;

  always @(negedge clk) if (!rst) begin
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc;
      acc_count++;
    end
    if (rsp_valid) begin
      exp_t e;
      rsp_count++;
      lat = cyc - acc_cyc;
      $display("rsp %0d: rdata=0x%03h err=%0b latency=%0d", rsp_count, rsp_rdata, rsp_err, lat);
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", rsp_count, rsp_count - 1);
      end else begin
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
    if (!ad_sload) begin
      if (hi_cnt > 0 && hi_cnt < min_hi) min_hi = hi_cnt;
      hi_cnt = 0;
      low_cnt++;
    end else begin
      if (low_cnt > 0) last_low = low_cnt;
      low_cnt = 0;
      hi_cnt++;
    end
    if (prev_oe && !ad_sdata_oe) begin
      oe_fall_at   = fcnt;
      oe_fall_sclk = ad_sclk;
    end
    prev_oe = ad_sdata_oe;
  end

  // ---------------- stimulus helpers ----------------
  logic [8:0] last_rd = '0;

  task automatic push_exp(input logic rw, input logic [8:0] data, input logic [8:0] readback);
    exp_t e;
    if (rw) begin
      e.rdata = readback; e.err = 1'b0; last_rd = readback;
    end else if (VERIFY) begin
      e.rdata = readback; e.err = (readback != data); last_rd = readback;
    end else begin
      e.rdata = last_rd; e.err = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic rw, input logic [2:0] addr, input logic [8:0] data);
    int start;
    start = acc_count;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = data;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (acc_count > start) break;
    end
    if (acc_count <= start) check("accept_timeout", acc_count, start + 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (rsp_count >= target) break;
      @(posedge clk);
    end
    if (rsp_count < target) check("rsp_timeout", rsp_count, target);
    @(negedge clk);
  endtask

  task automatic run_cmd(input logic rw, input logic [2:0] addr, input logic [8:0] data,
                         input logic [8:0] readback);
    int target;
    target = rsp_count + 1;
    push_exp(rw, data, readback);
    issue(rw, addr, data);
    wait_rsp(target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int f0, r0, a0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ovr_en = 1'b0; ovr_addr = '0; ovr_val = '0; corrupt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_sclk", ad_sclk, 0);
    check("rst_sload", ad_sload, 1);
    check("rst_sdata_o", ad_sdata_o, 0);
    check("rst_sdata_oe", ad_sdata_oe, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic write, frame contents and timing
    f0 = frames;
    run_cmd(1'b0, 3'b000, 9'h0D8, 9'h0D8);
    check("t1_frame", wr_frame, 16'h00D8);
    check("t1_sload_low", last_low, 136);
    check("t1_latency", lat, LAT);
    check("t1_busy_after", busy, 0);
    check("t1_ready_after", cmd_ready, 1);
    check("t1_frames", frames - f0, FR_PER_WR);

    // 2: write then read back through the model
    run_cmd(1'b0, 3'b101, 9'h0D8, 9'h0D8);
    run_cmd(1'b1, 3'b101, 9'h000, 9'h0D8);
    check("t2_oe_fall_bit", oe_fall_at, 7);
    check("t2_oe_fall_sclk", oe_fall_sclk, 0);

    // 3: read a value supplied by the model
    ovr_en = 1'b1; ovr_addr = 3'b000; ovr_val = 9'h155;
    run_cmd(1'b1, 3'b000, 9'h000, 9'h155);
    ovr_en = 1'b0;

    // 4: cmd_valid held across two commands
    r0 = rsp_count; a0 = acc_count; min_hi = 1000000;
    push_exp(1'b0, 9'h1A5, 9'h1A5);
    push_exp(1'b0, 9'h1A5, 9'h1A5);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'b010; cmd_wdata = 9'h1A5;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (acc_count >= a0 + 2) break;
    end
    if (acc_count < a0 + 2) check("t4_accept_timeout", acc_count, a0 + 2);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_rsp(r0 + 2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t4_rsp_pulses", rsp_count - r0, 2);
    check("t4_min_gap", min_hi, GAP_MIN);
    check("t4_accepts", acc_count - a0, 2);

    // 5: asynchronous reset in the middle of a write frame
    r0 = rsp_count;
    issue(1'b0, 3'b110, 9'h0AA);
    repeat (60) @(posedge clk);
    #3;
    check("t5_sclk_before_rst", ad_sclk, 1);
    rst = 1'b1;
    #1;
    check("t5_sload", ad_sload, 1);
    check("t5_sclk", ad_sclk, 0);
    check("t5_oe", ad_sdata_oe, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_rsp_rdata", rsp_rdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    last_rd = '0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("t5_no_rsp", rsp_count, r0);
    check("t5_sb_empty", sb_q.size(), 0);
    run_cmd(1'b0, 3'b001, 9'h033, 9'h033);
    run_cmd(1'b1, 3'b001, 9'h000, 9'h033);

    // 6: corrupted readback
    corrupt = 1'b1;
    f0 = frames;
    run_cmd(1'b0, 3'b011, 9'h0D8, 9'h0D9);
    check("t6_frames", frames - f0, FR_PER_WR);
    corrupt = 1'b0;

    repeat (10) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
